// File: rtl/cursor_ctrl_gen.sv
// Crosshair cursor controller: button movement with hold-to-accelerate, frozen
// position copy, menu hit-testing with per-item toggle bits, and crosshair pixel flag.
module cursor_ctrl_gen #(
    parameter int COORD_W    = 12,
    parameter int H_RES      = 1280,
    parameter int V_RES      = 1024,
    parameter int ARM_LEN    = 10,
    parameter int RAMP_DLY   = 3,
    parameter int MAX_SPD    = 63,
    parameter int N_ITEMS    = 5,
    parameter int ITEM_X0    = 1110,
    parameter int ITEM_X1    = 1150,
    parameter int ITEM_Y0    = 691,
    parameter int ITEM_PITCH = 25,
    parameter int ITEM_H     = 20,
    parameter logic [N_ITEMS-1:0] ITEM_INIT = 5'h0F,
    localparam int SPD_W = $clog2(MAX_SPD + 1),
    localparam int IDX_W = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               btn_l,
    input  logic               btn_r,
    input  logic               btn_u,
    input  logic               btn_d,
    input  logic               c_pulse,
    input  logic               freeze,
    input  logic               move_tick,
    input  logic               accel_tick,
    input  logic [COORD_W-1:0] vga_x,
    input  logic [COORD_W-1:0] vga_y,
    output logic [COORD_W-1:0] cursor_x,
    output logic [COORD_W-1:0] cursor_y,
    output logic [COORD_W-1:0] mem_x,
    output logic [COORD_W-1:0] mem_y,
    output logic [SPD_W-1:0]   speed,
    output logic               sel_valid,
    output logic [IDX_W-1:0]   sel_idx,
    output logic [N_ITEMS-1:0] item_state,
    output logic               pix_cursor
);

    localparam int CNT_W = (RAMP_DLY > 1) ? $clog2(RAMP_DLY + 1) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RAMP  = 2'd1;
    localparam logic [1:0] ST_ACCEL = 2'd2;

    localparam logic [1:0] DIR_L = 2'd0;
    localparam logic [1:0] DIR_R = 2'd1;
    localparam logic [1:0] DIR_U = 2'd2;
    localparam logic [1:0] DIR_D = 2'd3;

    localparam logic [COORD_W-1:0]        X_CTR = COORD_W'(H_RES / 2);
    localparam logic [COORD_W-1:0]        Y_CTR = COORD_W'(V_RES / 2);
    localparam logic signed [COORD_W:0]   X_MAX = (COORD_W + 1)'(H_RES - 1);
    localparam logic signed [COORD_W:0]   Y_MAX = (COORD_W + 1)'(V_RES - 1);
    localparam logic signed [COORD_W:0]   ONE_S = (COORD_W + 1)'(1);
    localparam logic [SPD_W-1:0]          SPD_MAX = SPD_W'(MAX_SPD);
    localparam logic [CNT_W-1:0]          CNT_LAST = CNT_W'(RAMP_DLY - 1);
    localparam logic [COORD_W-1:0]        ARM = COORD_W'(ARM_LEN);

    // Clamp a signed candidate coordinate into [0, lim]; never wraps.
    function automatic logic [COORD_W-1:0] sat_coord(input logic signed [COORD_W:0] v,
                                                     input logic signed [COORD_W:0] lim);
        if (v[COORD_W])
            return '0;
        else if (v > lim)
            return lim[COORD_W-1:0];
        else
            return v[COORD_W-1:0];
    endfunction

    function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                    input logic [COORD_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    logic [1:0]             state;
    logic [1:0]             held_dir;
    logic [CNT_W-1:0]       ramp_cnt;
    logic [2:0]             btn_cnt;
    logic                   any_btn;
    logic                   one_dir;
    logic [1:0]             cur_dir;
    logic signed [COORD_W:0] step_s;
    logic signed [COORD_W:0] x_ext;
    logic signed [COORD_W:0] y_ext;
    logic [COORD_W-1:0]     nxt_x;
    logic [COORD_W-1:0]     nxt_y;
    logic                   sel_qual;
    logic                   hit;
    logic [IDX_W-1:0]       hit_idx;
    logic                   pix_hit;

    assign btn_cnt = {2'b00, btn_l} + {2'b00, btn_r} + {2'b00, btn_u} + {2'b00, btn_d};
    assign any_btn = btn_l | btn_r | btn_u | btn_d;
    assign one_dir = en && (btn_cnt == 3'd1);
    assign sel_qual = c_pulse && en && !any_btn;

    always_comb begin
        cur_dir = DIR_L;
        if (btn_r)
            cur_dir = DIR_R;
        else if (btn_u)
            cur_dir = DIR_U;
        else if (btn_d)
            cur_dir = DIR_D;
    end

    // Step uses the speed value before this edge's accel update.
    assign step_s = $signed({{(COORD_W + 1 - SPD_W){1'b0}}, speed}) + ONE_S;
    assign x_ext  = $signed({1'b0, cursor_x});
    assign y_ext  = $signed({1'b0, cursor_y});

    always_comb begin
        nxt_x = cursor_x;
        nxt_y = cursor_y;
        if (move_tick && one_dir) begin
            case (cur_dir)
                DIR_L:   nxt_x = sat_coord(x_ext - step_s, X_MAX);
                DIR_R:   nxt_x = sat_coord(x_ext + step_s, X_MAX);
                DIR_U:   nxt_y = sat_coord(y_ext - step_s, Y_MAX);
                default: nxt_y = sat_coord(y_ext + step_s, Y_MAX);
            endcase
        end
    end

    // Walk downwards so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = N_ITEMS - 1; k >= 0; k--) begin
            if ((int'(cursor_x) > ITEM_X0) && (int'(cursor_x) < ITEM_X1) &&
                (int'(cursor_y) > ITEM_Y0 + k * ITEM_PITCH) &&
                (int'(cursor_y) < ITEM_Y0 + k * ITEM_PITCH + ITEM_H)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(k);
            end
        end
    end

    assign pix_hit = ((vga_x == cursor_x) && (abs_diff(vga_y, cursor_y) <= ARM)) ||
                     ((vga_y == cursor_y) && (abs_diff(vga_x, cursor_x) <= ARM));

    // Speed FSM: any loss of a single steady direction drops straight back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            held_dir <= DIR_L;
            ramp_cnt <= '0;
            speed    <= '0;
        end else if (!one_dir || (state != ST_IDLE && cur_dir != held_dir)) begin
            state    <= ST_IDLE;
            ramp_cnt <= '0;
            speed    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state    <= ST_RAMP;
                    held_dir <= cur_dir;
                    ramp_cnt <= '0;
                end
                ST_RAMP: begin
                    if (accel_tick) begin
                        if (ramp_cnt == CNT_LAST) begin
                            state    <= ST_ACCEL;
                            ramp_cnt <= '0;
                        end else begin
                            ramp_cnt <= ramp_cnt + 1'b1;
                        end
                    end
                end
                ST_ACCEL: begin
                    if (accel_tick && speed != SPD_MAX)
                        speed <= speed + 1'b1;
                end
                default: begin
                    state    <= ST_IDLE;
                    ramp_cnt <= '0;
                    speed    <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cursor_x <= X_CTR;
            cursor_y <= Y_CTR;
            mem_x    <= X_CTR;
            mem_y    <= Y_CTR;
        end else begin
            cursor_x <= nxt_x;
            cursor_y <= nxt_y;
            if (!freeze) begin
                mem_x <= cursor_x;
                mem_y <= cursor_y;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_valid  <= 1'b0;
            sel_idx    <= '0;
            item_state <= ITEM_INIT;
            pix_cursor <= 1'b0;
        end else begin
            sel_valid  <= sel_qual && hit;
            pix_cursor <= en && pix_hit;
            if (sel_qual && hit) begin
                sel_idx    <= hit_idx;
                item_state <= item_state ^ (N_ITEMS'(1) << hit_idx);
            end
        end
    end

endmodule

// File: tb/tb_cursor_ctrl_gen.sv
// Directed bench for cursor_ctrl_gen: movement, acceleration, clamping, select,
// freeze, enable gating, crosshair scan and mid-run reset.
module tb_cursor_ctrl_gen;

    localparam int DL = 0;
    localparam int DR = 1;
    localparam int DU = 2;
    localparam int DD = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b1;
    logic        btn_l = 1'b0, btn_r = 1'b0, btn_u = 1'b0, btn_d = 1'b0;
    logic        c_pulse = 1'b0;
    logic        freeze = 1'b0;
    logic        move_tick = 1'b0;
    logic        accel_tick = 1'b0;
    logic [11:0] vga_x = '0;
    logic [11:0] vga_y = '0;
    logic [11:0] cursor_x, cursor_y, mem_x, mem_y;
    logic [5:0]  speed;
    logic        sel_valid;
    logic [2:0]  sel_idx;
    logic [4:0]  item_state;
    logic        pix_cursor;

    int n_cmp = 0;
    int n_err = 0;
    int ex_x = 640;
    int ex_y = 512;

    always #5 clk = ~clk;

    cursor_ctrl_gen dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u), .btn_d(btn_d),
        .c_pulse(c_pulse), .freeze(freeze),
        .move_tick(move_tick), .accel_tick(accel_tick),
        .vga_x(vga_x), .vga_y(vga_y),
        .cursor_x(cursor_x), .cursor_y(cursor_y),
        .mem_x(mem_x), .mem_y(mem_y), .speed(speed),
        .sel_valid(sel_valid), .sel_idx(sel_idx),
        .item_state(item_state), .pix_cursor(pix_cursor)
    );

    task automatic set_btn(input int d, input logic v);
        case (d)
            DL: btn_l = v;
            DR: btn_r = v;
            DU: btn_u = v;
            default: btn_d = v;
        endcase
    endtask

    task automatic release_all();
        btn_l = 0; btn_r = 0; btn_u = 0; btn_d = 0;
        move_tick = 0; accel_tick = 0; c_pulse = 0;
    endtask

    task automatic sample();
        @(posedge clk);
        #1;
    endtask

    // Hold a direction with a move strobe every cycle for n cycles (speed stays 0), then one idle cycle.
    task automatic move_steps(input int d, input int n);
        @(negedge clk);
        set_btn(d, 1'b1);
        move_tick = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk);
        release_all();
        sample();
        case (d)
            DL: ex_x -= n;
            DR: ex_x += n;
            DU: ex_y -= n;
            default: ex_y += n;
        endcase
    endtask

    // Hold a direction (left held on return) and deliver `ticks` accel strobes.
    task automatic ramp(input int d, input int ticks);
        @(negedge clk);
        set_btn(d, 1'b1);
        @(posedge clk);
        repeat (ticks) begin
            @(negedge clk);
            accel_tick = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        accel_tick = 1'b0;
        sample();
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (cursor_x !== 12'd640) begin n_err++; $display("FAIL rst_cursor_x: got %0d exp 640", cursor_x); end
        n_cmp++; if (cursor_y !== 12'd512) begin n_err++; $display("FAIL rst_cursor_y: got %0d exp 512", cursor_y); end
        n_cmp++; if (mem_x !== 12'd640) begin n_err++; $display("FAIL rst_mem_x: got %0d exp 640", mem_x); end
        n_cmp++; if (mem_y !== 12'd512) begin n_err++; $display("FAIL rst_mem_y: got %0d exp 512", mem_y); end
        n_cmp++; if (speed !== 6'd0) begin n_err++; $display("FAIL rst_speed: got %0d exp 0", speed); end
        n_cmp++; if (sel_valid !== 1'b0) begin n_err++; $display("FAIL rst_sel_valid: got %b exp 0", sel_valid); end
        n_cmp++; if (sel_idx !== 3'd0) begin n_err++; $display("FAIL rst_sel_idx: got %0d exp 0", sel_idx); end
        n_cmp++; if (item_state !== 5'h0F) begin n_err++; $display("FAIL rst_item_state: got %h exp 0f", item_state); end
        n_cmp++; if (pix_cursor !== 1'b0) begin n_err++; $display("FAIL rst_pix: got %b exp 0", pix_cursor); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sample();
    endtask

    task automatic test_move_right();
        move_steps(DR, 5);
        n_cmp++; if (cursor_x !== 12'd645) begin n_err++; $display("FAIL move_r_x: got %0d exp 645", cursor_x); end
        n_cmp++; if (cursor_y !== 12'd512) begin n_err++; $display("FAIL move_r_y: got %0d exp 512", cursor_y); end
        n_cmp++; if (speed !== 6'd0) begin n_err++; $display("FAIL move_r_speed: got %0d exp 0", speed); end
        n_cmp++; if (mem_x !== 12'd645) begin n_err++; $display("FAIL move_r_mem_x: got %0d exp 645", mem_x); end
    endtask

    task automatic test_accel();
        ramp(DL, 7);
        n_cmp++; if (speed !== 6'd4) begin n_err++; $display("FAIL accel_speed: got %0d exp 4", speed); end
        n_cmp++; if (cursor_x !== 12'd645) begin n_err++; $display("FAIL accel_no_move: got %0d exp 645", cursor_x); end
        @(negedge clk);
        move_tick = 1'b1;
        sample();
        n_cmp++; if (cursor_x !== 12'd640) begin n_err++; $display("FAIL accel_step5: got %0d exp 640", cursor_x); end
        @(negedge clk);
        release_all();
        sample();
        n_cmp++; if (speed !== 6'd0) begin n_err++; $display("FAIL accel_release_speed: got %0d exp 0", speed); end
        // direction change while accelerating drops speed
        ramp(DL, 5);
        n_cmp++; if (speed !== 6'd2) begin n_err++; $display("FAIL accel_speed2: got %0d exp 2", speed); end
        @(negedge clk);
        btn_l = 1'b0;
        btn_r = 1'b1;
        sample();
        n_cmp++; if (speed !== 6'd0) begin n_err++; $display("FAIL dirchg_speed: got %0d exp 0", speed); end
        // two buttons held: no movement
        @(negedge clk);
        release_all();
        btn_l = 1'b1;
        btn_u = 1'b1;
        move_tick = 1'b1;
        sample();
        n_cmp++; if (cursor_x !== 12'd640 || cursor_y !== 12'd512) begin
            n_err++; $display("FAIL two_btn_hold: got (%0d,%0d) exp (640,512)", cursor_x, cursor_y);
        end
        @(negedge clk);
        release_all();
        sample();
        ex_x = 640;
        ex_y = 512;
    endtask

    task automatic test_clamp();
        move_steps(DL, 638);
        n_cmp++; if (cursor_x !== 12'd2) begin n_err++; $display("FAIL clamp_pre_l: got %0d exp 2", cursor_x); end
        ramp(DL, 13);
        n_cmp++; if (speed !== 6'd10) begin n_err++; $display("FAIL clamp_speed_l: got %0d exp 10", speed); end
        @(negedge clk);
        move_tick = 1'b1;
        sample();
        n_cmp++; if (cursor_x !== 12'd0) begin n_err++; $display("FAIL clamp_left: got %0d exp 0", cursor_x); end
        sample();
        n_cmp++; if (cursor_x !== 12'd0) begin n_err++; $display("FAIL clamp_left_hold: got %0d exp 0", cursor_x); end
        @(negedge clk);
        release_all();
        sample();
        ex_x = 0;
        move_steps(DR, 1278);
        n_cmp++; if (cursor_x !== 12'd1278) begin n_err++; $display("FAIL clamp_pre_r: got %0d exp 1278", cursor_x); end
        ramp(DR, 13);
        @(negedge clk);
        move_tick = 1'b1;
        sample();
        n_cmp++; if (cursor_x !== 12'd1279) begin n_err++; $display("FAIL clamp_right: got %0d exp 1279", cursor_x); end
        sample();
        n_cmp++; if (cursor_x !== 12'd1279) begin n_err++; $display("FAIL clamp_right_hold: got %0d exp 1279", cursor_x); end
        @(negedge clk);
        release_all();
        sample();
        ex_x = 1279;
    endtask

    task automatic test_select();
        move_steps(DL, 149);
        move_steps(DD, 188);
        n_cmp++; if (cursor_x !== 12'(ex_x) || cursor_y !== 12'(ex_y) || ex_x != 1130 || ex_y != 700) begin
            n_err++; $display("FAIL sel_place: got (%0d,%0d) exp (1130,700)", cursor_x, cursor_y);
        end
        @(negedge clk);
        c_pulse = 1'b1;
        sample();
        n_cmp++; if (sel_valid !== 1'b1) begin n_err++; $display("FAIL sel0_valid: got %b exp 1", sel_valid); end
        n_cmp++; if (sel_idx !== 3'd0) begin n_err++; $display("FAIL sel0_idx: got %0d exp 0", sel_idx); end
        n_cmp++; if (item_state !== 5'h0E) begin n_err++; $display("FAIL sel0_state: got %h exp 0e", item_state); end
        @(negedge clk);
        c_pulse = 1'b0;
        sample();
        n_cmp++; if (sel_valid !== 1'b0) begin n_err++; $display("FAIL sel0_pulse_end: got %b exp 0", sel_valid); end
        move_steps(DD, 15);
        @(negedge clk);
        c_pulse = 1'b1;
        sample();
        n_cmp++; if (sel_valid !== 1'b0 || item_state !== 5'h0E) begin
            n_err++; $display("FAIL sel_gap: got valid %b state %h exp 0 0e", sel_valid, item_state);
        end
        @(negedge clk);
        c_pulse = 1'b0;
        sample();
        move_steps(DU, 15);
        @(negedge clk);
        btn_u = 1'b1;
        c_pulse = 1'b1;
        sample();
        n_cmp++; if (sel_valid !== 1'b0 || item_state !== 5'h0E) begin
            n_err++; $display("FAIL sel_btn_held: got valid %b state %h exp 0 0e", sel_valid, item_state);
        end
        n_cmp++; if (cursor_y !== 12'd700) begin n_err++; $display("FAIL sel_btn_no_move: got %0d exp 700", cursor_y); end
        @(negedge clk);
        release_all();
        sample();
        move_steps(DD, 50);
        @(negedge clk);
        c_pulse = 1'b1;
        sample();
        n_cmp++; if (sel_valid !== 1'b1 || sel_idx !== 3'd2 || item_state !== 5'h0A) begin
            n_err++; $display("FAIL sel2: got valid %b idx %0d state %h exp 1 2 0a", sel_valid, sel_idx, item_state);
        end
        @(negedge clk);
        c_pulse = 1'b0;
        sample();
    endtask

    task automatic test_freeze();
        @(negedge clk);
        freeze = 1'b1;
        sample();
        move_steps(DR, 10);
        n_cmp++; if (cursor_x !== 12'd1140) begin n_err++; $display("FAIL frz_cursor: got %0d exp 1140", cursor_x); end
        n_cmp++; if (mem_x !== 12'd1130 || mem_y !== 12'd750) begin
            n_err++; $display("FAIL frz_hold: got (%0d,%0d) exp (1130,750)", mem_x, mem_y);
        end
        @(negedge clk);
        freeze = 1'b0;
        sample();
        n_cmp++; if (mem_x !== 12'd1140) begin n_err++; $display("FAIL frz_release: got %0d exp 1140", mem_x); end
        @(negedge clk);
        btn_r = 1'b1;
        move_tick = 1'b1;
        sample();
        n_cmp++; if (cursor_x !== 12'd1141 || mem_x !== 12'd1140) begin
            n_err++; $display("FAIL mem_lag: got cursor %0d mem %0d exp 1141 1140", cursor_x, mem_x);
        end
        @(negedge clk);
        release_all();
        sample();
        n_cmp++; if (mem_x !== 12'd1141) begin n_err++; $display("FAIL mem_track: got %0d exp 1141", mem_x); end
        ex_x = 1141;
    endtask

    task automatic test_enable();
        @(negedge clk);
        en = 1'b0;
        btn_r = 1'b1;
        move_tick = 1'b1;
        vga_x = 12'd1141;
        vga_y = 12'd750;
        sample();
        n_cmp++; if (cursor_x !== 12'd1141) begin n_err++; $display("FAIL en0_hold: got %0d exp 1141", cursor_x); end
        n_cmp++; if (pix_cursor !== 1'b0) begin n_err++; $display("FAIL en0_pix: got %b exp 0", pix_cursor); end
        @(negedge clk);
        release_all();
        c_pulse = 1'b1;
        sample();
        n_cmp++; if (sel_valid !== 1'b0 || item_state !== 5'h0A) begin
            n_err++; $display("FAIL en0_sel: got valid %b state %h exp 0 0a", sel_valid, item_state);
        end
        @(negedge clk);
        c_pulse = 1'b0;
        en = 1'b1;
        sample();
        n_cmp++; if (pix_cursor !== 1'b1) begin n_err++; $display("FAIL en1_pix: got %b exp 1", pix_cursor); end
    endtask

    task automatic test_pix_scan();
        int px [10] = '{0, 10, 11, 0, 0, 5, 4095, 0, 1, 3};
        int py [10] = '{0, 0, 0, 10, 11, 5, 0, 4095, 1, 0};
        logic pe [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        move_steps(DL, 1141);
        move_steps(DU, 750);
        n_cmp++; if (cursor_x !== 12'd0 || cursor_y !== 12'd0) begin
            n_err++; $display("FAIL pix_place: got (%0d,%0d) exp (0,0)", cursor_x, cursor_y);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vga_x = 12'(px[i]);
            vga_y = 12'(py[i]);
            sample();
            n_cmp++; if (pix_cursor !== pe[i]) begin
                n_err++; $display("FAIL pix_scan(%0d,%0d): got %b exp %b", px[i], py[i], pix_cursor, pe[i]);
            end
        end
        @(negedge clk);
        vga_x = 12'd50;
        vga_y = 12'd50;
        #1;
        n_cmp++; if (pix_cursor !== 1'b1) begin n_err++; $display("FAIL pix_latency_old: got %b exp 1", pix_cursor); end
        sample();
        n_cmp++; if (pix_cursor !== 1'b0) begin n_err++; $display("FAIL pix_latency_new: got %b exp 0", pix_cursor); end
    endtask

    task automatic test_reset_mid_accel();
        ramp(DR, 5);
        n_cmp++; if (speed !== 6'd2) begin n_err++; $display("FAIL mid_speed: got %0d exp 2", speed); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (speed !== 6'd0) begin n_err++; $display("FAIL mid_rst_speed: got %0d exp 0", speed); end
        n_cmp++; if (cursor_x !== 12'd640 || cursor_y !== 12'd512) begin
            n_err++; $display("FAIL mid_rst_cursor: got (%0d,%0d) exp (640,512)", cursor_x, cursor_y);
        end
        n_cmp++; if (item_state !== 5'h0F) begin n_err++; $display("FAIL mid_rst_state: got %h exp 0f", item_state); end
        @(negedge clk);
        release_all();
        rst_n = 1'b1;
        sample();
        n_cmp++; if (speed !== 6'd0 || cursor_x !== 12'd640) begin
            n_err++; $display("FAIL mid_after: got speed %0d x %0d exp 0 640", speed, cursor_x);
        end
    endtask

    initial begin
        test_reset();
        test_move_right();
        test_accel();
        test_clamp();
        test_select();
        test_freeze();
        test_enable();
        test_pix_scan();
        test_reset_mid_accel();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
